// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALUCTL_ADD = 3'b000;
  localparam logic [2:0] ALUCTL_SUB = 3'b001;
  localparam logic [2:0] ALUCTL_AND = 3'b010;
  localparam logic [2:0] ALUCTL_OR  = 3'b011;
  localparam logic [2:0] ALUCTL_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_ITYPE) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_aludec.sv
// ALU decoder: maps ALUOp plus instruction function fields to an ALU operation.
module aludec
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALUCTL_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (funct7b5 & op5) ? ALUCTL_SUB : ALUCTL_ADD;
          3'b010:  alu_control = ALUCTL_SLT;
          3'b110:  alu_control = ALUCTL_OR;
          3'b111:  alu_control = ALUCTL_AND;
          default: alu_control = ALUCTL_ADD;
        endcase
      end
      default: alu_control = ALUCTL_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch/decode/execute,
// memory handshake via mem_ready, plus ImmSrc decode and ALU decode.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       instr_retired,
  output logic       illegal_op
);

  state_t     state;
  state_t     cur;
  logic [1:0] alu_op;
  logic       branch, pc_update, ir_write, mem_write, reg_write, retired, illegal;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:    state <= mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_RTYPE:     state <= S_EXECR;
            OP_ITYPE:     state <= S_EXECI;
            OP_BEQ:       state <= S_BEQ;
            OP_JAL:       state <= S_JAL;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  state <= mem_ready ? S_MEMWB : S_MEMREAD;
        S_MEMWRITE: state <= mem_ready ? S_FETCH : S_MEMWRITE;
        S_EXECR,
        S_EXECI,
        S_JAL:      state <= S_ALUWB;
        default:    state <= S_FETCH;
      endcase
    end
  end

  // While reset is held the outputs decode as FETCH, with enables then masked.
  assign cur = reset_n ? state : S_FETCH;

  always_comb begin
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    alu_op    = ALUOP_ADD;
    branch    = 1'b0;
    pc_update = 1'b0;
    ir_write  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    retired   = 1'b0;
    illegal   = 1'b0;
    case (cur)
      S_FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_write  = mem_ready;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        illegal = ~op_supported(op);
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
        retired   = mem_ready;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_FUNCT;
      end
      S_EXECI: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retired   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = SRCA_RD1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
        retired = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWrite       = reset_n & ((Zero & branch) | pc_update);
  assign IRWrite       = reset_n & ir_write;
  assign MemWrite      = reset_n & mem_write;
  assign RegWrite      = reset_n & reg_write;
  assign instr_retired = reset_n & retired;
  assign illegal_op    = reset_n & illegal;

  always_comb begin
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  aludec u_aludec (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings are fixed constants from the shared package.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, synchronous and active-low.
REQ-004 op  in  7  instruction opcode field, from instruction register.
REQ-005 funct3  in  3  instruction funct3 field.
REQ-006 funct7b5  in  1  instruction bit 30.
REQ-007 Zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory access completes in the current cycle.
REQ-009 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath enables/selects.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  datapath mux selects.
REQ-011 ALUControl  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-012 instr_retired  out  1  one-cycle pulse when an instruction completes.
REQ-013 illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

Function
REQ-014 Moore FSM, states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-015 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, IRWrite=PCUpdate=mem_ready; stay while mem_ready=0, else go to DECODE.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-017 DECODE transitions: 0000011 or 0100011 -> MEMADR, 0110011 -> EXECR, 0010011 -> EXECI, 1100011 -> BEQ, 1101111 -> JAL, other -> FETCH with illegal_op=1.
REQ-018 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next is MEMREAD if op=0000011, else MEMWRITE.
REQ-019 MEMREAD: AdrSrc=1, ResultSrc=00; hold until mem_ready=1, then go to MEMWB.
REQ-020 MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held every wait cycle; on mem_ready=1 go to FETCH and pulse instr_retired.
REQ-021 MEMWB: ResultSrc=01, RegWrite=1; then FETCH and instr_retired=1.
REQ-022 EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Both go to ALUWB.
REQ-023 ALUWB: ResultSrc=00, RegWrite=1; then FETCH and instr_retired=1.
REQ-024 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; then FETCH and instr_retired=1.
REQ-025 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; then ALUWB.
REQ-026 PCWrite = (Zero & Branch) | PCUpdate.
REQ-027 All unlisted outputs in any state are 0.
REQ-028 ImmSrc decodes combinationally from op: I/lw 00, sw 01, beq 10, jal 11, others 00.
REQ-029 ALUControl derivation:
- ALUOp 00 -> add; ALUOp 01 -> sub.
- ALUOp 10 -> funct3 000 gives sub if funct7b5&op[5], else add; 010 gives slt; 110 gives or; 111 gives and; other funct3 gives add.
REQ-030 Cycle counts with mem_ready tied high: lw 5, sw 4, R/I 4, beq 3, jal 4.
REQ-031 Unreachable state encodings return to FETCH on the next edge.

Reset
REQ-032 reset_n=0 sampled on an edge sets state to FETCH.
REQ-033 While reset_n=0, force PCWrite, IRWrite, MemWrite, RegWrite, instr_retired and illegal_op to 0; mux selects take FETCH values.
REQ-034 Reset mid-instruction, including a stalled MEMWRITE, abandons it: no further write enables and no retire pulse.

Structure
REQ-035 Shared package riscv_pkg holds:
- state enum;
- opcode constants;
- ALUOp and ALUControl encodings;
- ResultSrc, ALUSrcA and ALUSrcB encodings.
REQ-036 One sub-module, aludec, implements REQ-029; main FSM and ImmSrc decode stay in multicycle_ctrl.

Verification
REQ-037 lw (op=0000011), mem_ready=1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 and ResultSrc=01 only in cycle 5; instr_retired=1 in cycle 5.
REQ-038 sw, mem_ready low 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, single instr_retired, no RegWrite.
REQ-039 R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; add (funct7b5=0) -> 000; or (110) -> 011; slt (010) -> 101.
REQ-040 beq with Zero=1 -> PCWrite=1 in BEQ state; Zero=0 -> PCWrite=0; 3 cycles total.
REQ-041 FETCH with mem_ready=0 for 2 cycles -> IRWrite=PCWrite=0 for 2 cycles, then exactly one cycle of both =1.
REQ-042 Two stimuli:
- op=1111111 -> illegal_op pulses in DECODE, FETCH follows.
- reset_n=0 during MEMREAD -> FETCH next edge, all enables 0.
